// File: rtl/reg_native_apb_pkg.sv
// Shared types and helpers for the native-register-interface to APB requester bridge.
package reg_native_apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_e;

  // Counter width able to hold 0..n; at least one bit so a disabled timeout still elaborates.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_native_req_buf.sv
// One-entry command buffer holding a request that arrived while a transfer was in flight.
module reg_native_req_buf #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] pop_data,
  output logic             full
);

  logic [Width-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (pop) begin
        full_q <= 1'b0;
      end
      if (push) begin
        full_q <= 1'b1;
        data_q <= push_data;
      end
    end
  end

  assign pop_data = data_q;
  assign full     = full_q;

endmodule

// File: rtl/reg_native_if2apb.sv
// APB3 requester bridge: issues native single-beat register requests as APB transfers,
// with a one-entry request buffer and a PREADY timeout that forces an error completion.
module reg_native_if2apb
  import reg_native_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  err,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  localparam int unsigned CmdWidth = $bits(cmd_t);
  localparam int unsigned CntWidth = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TIMEOUT_CYCLES);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  logic [CntWidth-1:0] tmo_cnt_q;

  logic req_ok;
  logic buf_full;
  logic buf_push;
  logic buf_pop;
  logic tmo_hit;
  cmd_t req_cmd;
  cmd_t buf_cmd;
  cmd_t load_cmd;

  // A simultaneous write+read strobe is executed as a write.
  always_comb begin
    req_ok        = req_vld & (wr_en | rd_en);
    req_cmd.write = wr_en;
    req_cmd.addr  = addr;
    req_cmd.wdata = wr_data;
  end

  // Requests arriving mid-transfer go to the buffer; a full buffer drops them (busy was high).
  always_comb begin
    buf_push = req_ok && (state_q != S_IDLE) && !buf_full;
    buf_pop  = buf_full && ((state_q == S_IDLE) || (state_q == S_ACK));
    load_cmd = buf_full ? buf_cmd : req_cmd;
    tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CntLast);
  end

  reg_native_req_buf #(
    .Width(CmdWidth)
  ) u_req_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .pop      (buf_pop),
    .push_data(req_cmd),
    .pop_data (buf_cmd),
    .full     (buf_full)
  );

  assign busy = buf_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      ack_vld   <= 1'b0;
      rd_data   <= '0;
      err       <= 1'b0;
    end else begin
      ack_vld <= 1'b0;
      rd_data <= '0;
      err     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (buf_full || req_ok) begin
            state_q <= S_SETUP;
            psel    <= 1'b1;
            pwrite  <= load_cmd.write;
            paddr   <= load_cmd.addr;
            pwdata  <= load_cmd.wdata;
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable   <= 1'b1;
          tmo_cnt_q <= '0;
        end
        S_ACCESS: begin
          if (pready) begin
            state_q <= S_ACK;
            psel    <= 1'b0;
            penable <= 1'b0;
            ack_vld <= 1'b1;
            rd_data <= pwrite ? '0 : prdata;
            err     <= pslverr;
          end else if (tmo_hit) begin
            // Abandon the stuck completer so the requester always gets an ack.
            state_q <= S_ACK;
            psel    <= 1'b0;
            penable <= 1'b0;
            ack_vld <= 1'b1;
            err     <= 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q != CntMax)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_ACK: begin
          if (buf_full) begin
            state_q <= S_SETUP;
            psel    <= 1'b1;
            pwrite  <= buf_cmd.write;
            paddr   <= buf_cmd.addr;
            pwdata  <= buf_cmd.wdata;
          end else begin
            state_q <= S_IDLE;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_native_if2apb.sv
// Directed bench for reg_native_if2apb with hand-computed cycle-by-cycle expectations.
module tb_reg_native_if2apb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld, wr_en, rd_en;
  logic [63:0] addr;
  logic [31:0] wr_data;
  logic        ack_vld;
  logic [31:0] rd_data;
  logic        err, busy;
  logic        psel, penable, pwrite;
  logic [63:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_native_if2apb #(
    .ADDR_WIDTH    (64),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_vld(req_vld),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wr_data(wr_data),
    .ack_vld(ack_vld),
    .rd_data(rd_data),
    .err    (err),
    .busy   (busy),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d);
    req_vld = 1'b1;
    wr_en   = w;
    rd_en   = r;
    addr    = a;
    wr_data = d;
  endtask

  task automatic noreq();
    req_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wr_data = '0;
  endtask

  initial begin
    rst     = 1'b1;
    noreq();
    pready  = 1'b1;
    prdata  = '0;
    pslverr = 1'b0;
    step();
    step();

    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", paddr, 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_ack", 64'(ack_vld), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    // Write 0x40 <- 0xDEADBEEF, zero-wait completer.
    prdata = 32'hFFFF_FFFF;
    req(1'b1, 1'b0, 64'h40, 32'hDEAD_BEEF);
    step();
    noreq();
    chk("wr_c1_psel", 64'(psel), 64'd1);
    chk("wr_c1_penable", 64'(penable), 64'd0);
    chk("wr_c1_pwrite", 64'(pwrite), 64'd1);
    chk("wr_c1_paddr", paddr, 64'h40);
    chk("wr_c1_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    step();
    chk("wr_c2_psel", 64'(psel), 64'd1);
    chk("wr_c2_penable", 64'(penable), 64'd1);
    chk("wr_c2_ack", 64'(ack_vld), 64'd0);
    step();
    chk("wr_c3_ack", 64'(ack_vld), 64'd1);
    chk("wr_c3_err", 64'(err), 64'd0);
    chk("wr_c3_rd_data", 64'(rd_data), 64'd0);
    chk("wr_c3_psel", 64'(psel), 64'd0);
    step();
    chk("wr_c4_ack", 64'(ack_vld), 64'd0);
    chk("wr_c4_paddr", paddr, 64'd0);
    chk("wr_c4_pwrite", 64'(pwrite), 64'd0);

    // Read 0x10 with two wait states.
    pready = 1'b0;
    prdata = 32'h1234_5678;
    req(1'b0, 1'b1, 64'h10, 32'h0);
    step();
    noreq();
    chk("rd_c1_pwrite", 64'(pwrite), 64'd0);
    chk("rd_c1_paddr", paddr, 64'h10);
    step();
    chk("rd_c2_penable", 64'(penable), 64'd1);
    step();
    chk("rd_c3_ack", 64'(ack_vld), 64'd0);
    step();
    pready = 1'b1;
    chk("rd_c4_ack", 64'(ack_vld), 64'd0);
    chk("rd_c4_psel", 64'(psel), 64'd1);
    step();
    chk("rd_c5_ack", 64'(ack_vld), 64'd1);
    chk("rd_c5_rd_data", 64'(rd_data), 64'h1234_5678);
    chk("rd_c5_err", 64'(err), 64'd0);
    step();
    chk("rd_c6_rd_data", 64'(rd_data), 64'd0);

    // Write completed with pslverr.
    pslverr = 1'b1;
    req(1'b1, 1'b0, 64'h80, 32'h5);
    step();
    noreq();
    step();
    step();
    chk("slverr_ack", 64'(ack_vld), 64'd1);
    chk("slverr_err", 64'(err), 64'd1);
    pslverr = 1'b0;
    step();
    chk("slverr_err_clr", 64'(err), 64'd0);

    // Strobe with neither enable is ignored.
    req_vld = 1'b1;
    addr    = 64'h99;
    step();
    noreq();
    chk("noen_psel", 64'(psel), 64'd0);
    chk("noen_busy", 64'(busy), 64'd0);
    step();

    // Two requests one cycle apart: buffered second transfer, acks three cycles apart.
    prdata = 32'hCAFE_0001;
    req(1'b1, 1'b0, 64'h100, 32'h1);
    step();
    req(1'b0, 1'b1, 64'h104, 32'h0);
    chk("b2b_c1_busy", 64'(busy), 64'd0);
    step();
    noreq();
    chk("b2b_c2_busy", 64'(busy), 64'd1);
    chk("b2b_c2_paddr", paddr, 64'h100);
    step();
    chk("b2b_c3_ack", 64'(ack_vld), 64'd1);
    chk("b2b_c3_rd_data", 64'(rd_data), 64'd0);
    step();
    chk("b2b_c4_ack", 64'(ack_vld), 64'd0);
    chk("b2b_c4_psel", 64'(psel), 64'd1);
    chk("b2b_c4_penable", 64'(penable), 64'd0);
    chk("b2b_c4_paddr", paddr, 64'h104);
    chk("b2b_c4_pwrite", 64'(pwrite), 64'd0);
    chk("b2b_c4_busy", 64'(busy), 64'd0);
    step();
    chk("b2b_c5_ack", 64'(ack_vld), 64'd0);
    step();
    chk("b2b_c6_ack", 64'(ack_vld), 64'd1);
    chk("b2b_c6_rd_data", 64'(rd_data), 64'hCAFE_0001);
    step();

    // Timeout after four ACCESS cycles with pready stuck low.
    pready = 1'b0;
    prdata = 32'hAAAA_5555;
    req(1'b0, 1'b1, 64'h20, 32'h0);
    step();
    noreq();
    step();
    step();
    step();
    step();
    chk("tmo_c5_psel", 64'(psel), 64'd1);
    chk("tmo_c5_ack", 64'(ack_vld), 64'd0);
    step();
    chk("tmo_c6_psel", 64'(psel), 64'd0);
    chk("tmo_c6_ack", 64'(ack_vld), 64'd1);
    chk("tmo_c6_err", 64'(err), 64'd1);
    chk("tmo_c6_rd_data", 64'(rd_data), 64'd0);
    pready = 1'b1;
    prdata = 32'h0000_0077;
    step();
    req(1'b0, 1'b1, 64'h24, 32'h0);
    step();
    noreq();
    step();
    step();
    chk("post_tmo_ack", 64'(ack_vld), 64'd1);
    chk("post_tmo_err", 64'(err), 64'd0);
    chk("post_tmo_rd_data", 64'(rd_data), 64'h77);
    step();

    // Reset during ACCESS with a buffered request: everything clears, no ack.
    pready = 1'b0;
    req(1'b1, 1'b0, 64'h200, 32'h11);
    step();
    req(1'b1, 1'b0, 64'h204, 32'h22);
    step();
    noreq();
    chk("rst_mid_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst    = 1'b0;
    pready = 1'b1;
    chk("rst_mid_psel", 64'(psel), 64'd0);
    chk("rst_mid_penable", 64'(penable), 64'd0);
    chk("rst_mid_pwrite", 64'(pwrite), 64'd0);
    chk("rst_mid_paddr", paddr, 64'd0);
    chk("rst_mid_pwdata", 64'(pwdata), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ack", 64'(ack_vld), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_no_ack", 64'(ack_vld), 64'd0);
      chk("rst_mid_no_psel", 64'(psel), 64'd0);
    end
    prdata = 32'h0BAD_F00D;
    req(1'b0, 1'b1, 64'h30, 32'h0);
    step();
    noreq();
    chk("post_rst_paddr", paddr, 64'h30);
    step();
    step();
    chk("post_rst_ack", 64'(ack_vld), 64'd1);
    chk("post_rst_rd_data", 64'(rd_data), 64'h0BAD_F00D);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
